// File: rtl/ex_mem_skid_reg_if.sv
// Handshake and data bundle between the EX stage, the EX/MEM skid register and the MEM stage.
// The slave modport is the register's view; the master modport is the view of whatever surrounds it.
interface ex_mem_skid_reg_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_result;
    logic        in_lt;
    logic        in_slt;
    logic [15:0] in_store_data;
    logic [3:0]  in_rd;
    logic [2:0]  in_ctrl;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [15:0] out_store_data;
    logic [3:0]  out_rd;
    logic [2:0]  out_ctrl;
    logic [7:0]  stall_cnt;

    modport slave (
        input  in_valid, in_result, in_lt, in_slt, in_store_data, in_rd, in_ctrl,
        input  flush, out_ready,
        output in_ready, out_valid, out_result, out_store_data, out_rd, out_ctrl, stall_cnt
    );

    modport master (
        output in_valid, in_result, in_lt, in_slt, in_store_data, in_rd, in_ctrl,
        output flush, out_ready,
        input  in_ready, out_valid, out_result, out_store_data, out_rd, out_ctrl, stall_cnt
    );
endinterface

// File: rtl/ex_mem_skid_reg.sv
// EX/MEM pipeline register with a one-entry skid buffer, so that in_ready is driven from flops only.
// Also counts cycles the MEM stage spends backpressuring a valid entry.
module ex_mem_skid_reg (
    input logic              clk,
    input logic              reset,
    ex_mem_skid_reg_if.slave bus
);
    typedef struct packed {
        logic [15:0] result;
        logic [15:0] storeData;
        logic [3:0]  rd;
        logic [2:0]  ctrl;
    } entry_t;

    entry_t     main_q, main_d, skid_q, skid_d, incoming;
    logic       mainValid_q, mainValid_d;
    logic       skidValid_q, skidValid_d;
    logic [7:0] stallCnt_q, stallCnt_d;
    logic       inReady, accept, transfer;

    // SLT results collapse to the comparator bit before they are stored.
    always_comb begin
        incoming.result    = bus.in_slt ? {15'b0, bus.in_lt} : bus.in_result;
        incoming.storeData = bus.in_store_data;
        incoming.rd        = bus.in_rd;
        incoming.ctrl      = bus.in_ctrl;
    end

    assign inReady  = ~skidValid_q;
    assign accept   = bus.in_valid & inReady;
    assign transfer = mainValid_q & bus.out_ready;

    always_comb begin
        main_d      = main_q;
        skid_d      = skid_q;
        mainValid_d = mainValid_q;
        skidValid_d = skidValid_q;
        stallCnt_d  = stallCnt_q;

        if (mainValid_q && !bus.out_ready && stallCnt_q != 8'hFF) begin
            stallCnt_d = stallCnt_q + 8'd1;
        end

        if (bus.flush) begin
            mainValid_d = 1'b0;
            skidValid_d = 1'b0;
        end else if (!mainValid_q) begin
            if (accept) begin
                main_d      = incoming;
                mainValid_d = 1'b1;
            end
        end else if (transfer) begin
            // A full skid means in_ready was low, so nothing new can arrive this cycle.
            if (skidValid_q) begin
                main_d      = skid_q;
                skidValid_d = 1'b0;
            end else if (accept) begin
                main_d = incoming;
            end else begin
                mainValid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d      = incoming;
            skidValid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_q      <= '0;
            skid_q      <= '0;
            mainValid_q <= 1'b0;
            skidValid_q <= 1'b0;
            stallCnt_q  <= 8'd0;
        end else begin
            main_q      <= main_d;
            skid_q      <= skid_d;
            mainValid_q <= mainValid_d;
            skidValid_q <= skidValid_d;
            stallCnt_q  <= stallCnt_d;
        end
    end

    assign bus.in_ready       = inReady;
    assign bus.out_valid      = mainValid_q;
    assign bus.out_result     = main_q.result;
    assign bus.out_store_data = main_q.storeData;
    assign bus.out_rd         = main_q.rd;
    assign bus.out_ctrl       = main_q.ctrl;
    assign bus.stall_cnt      = stallCnt_q;
endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Directed bench for ex_mem_skid_reg: each scenario task drives vectors and checks hand-computed values.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_ex_mem_skid_reg;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    ex_mem_skid_reg_if bus ();

    ex_mem_skid_reg dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        bus.in_valid      = 1'b0;
        bus.in_result     = 16'h0000;
        bus.in_lt         = 1'b0;
        bus.in_slt        = 1'b0;
        bus.in_store_data = 16'h0000;
        bus.in_rd         = 4'd0;
        bus.in_ctrl       = 3'b000;
        bus.flush         = 1'b0;
        bus.out_ready     = 1'b0;
    endtask

    task automatic offer(input logic [15:0] result, input logic [3:0] rd);
        bus.in_valid      = 1'b1;
        bus.in_slt        = 1'b0;
        bus.in_lt         = 1'b0;
        bus.in_result     = result;
        bus.in_store_data = ~result;
        bus.in_rd         = rd;
        bus.in_ctrl       = 3'b010;
    endtask

    task automatic doReset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idleInputs();
        doReset();
        checks += 7;
        if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %0b want 0", bus.out_valid); end
        if (bus.out_result !== 16'h0000) begin errors++; $display("[TB] FAIL reset_out_result got %h want 0000", bus.out_result); end
        if (bus.out_store_data !== 16'h0000) begin errors++; $display("[TB] FAIL reset_out_store_data got %h want 0000", bus.out_store_data); end
        if (bus.out_rd !== 4'd0) begin errors++; $display("[TB] FAIL reset_out_rd got %0d want 0", bus.out_rd); end
        if (bus.out_ctrl !== 3'b000) begin errors++; $display("[TB] FAIL reset_out_ctrl got %b want 000", bus.out_ctrl); end
        if (bus.stall_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_stall_cnt got %0d want 0", bus.stall_cnt); end
        if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %0b want 1", bus.in_ready); end
    endtask

    task automatic test_slt();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_slt    = 1'b1;
        bus.in_lt     = 1'b1;
        bus.in_result = 16'h8003;
        bus.in_rd     = 4'd7;
        bus.in_ctrl   = 3'b100;
        tick();
        bus.in_valid = 1'b0;
        bus.in_slt   = 1'b0;
        checks += 3;
        if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL slt_out_valid got %0b want 1", bus.out_valid); end
        if (bus.out_result !== 16'h0001) begin errors++; $display("[TB] FAIL slt_out_result got %h want 0001", bus.out_result); end
        if (bus.out_rd !== 4'd7) begin errors++; $display("[TB] FAIL slt_out_rd got %0d want 7", bus.out_rd); end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL slt_drain_out_valid got %0b want 0", bus.out_valid); end
    endtask

    task automatic test_non_slt();
        bus.out_ready     = 1'b1;
        bus.in_valid      = 1'b1;
        bus.in_slt        = 1'b0;
        bus.in_lt         = 1'b1;
        bus.in_result     = 16'h1234;
        bus.in_store_data = 16'hBEEF;
        bus.in_rd         = 4'd5;
        bus.in_ctrl       = 3'b100;
        tick();
        bus.in_valid = 1'b0;
        checks += 5;
        if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL alu_out_valid got %0b want 1", bus.out_valid); end
        if (bus.out_result !== 16'h1234) begin errors++; $display("[TB] FAIL alu_out_result got %h want 1234", bus.out_result); end
        if (bus.out_store_data !== 16'hBEEF) begin errors++; $display("[TB] FAIL alu_out_store_data got %h want beef", bus.out_store_data); end
        if (bus.out_rd !== 4'd5) begin errors++; $display("[TB] FAIL alu_out_rd got %0d want 5", bus.out_rd); end
        if (bus.out_ctrl !== 3'b100) begin errors++; $display("[TB] FAIL alu_out_ctrl got %b want 100", bus.out_ctrl); end
        tick();
    endtask

    task automatic test_back_to_back();
        idleInputs();
        offer(16'h0011, 4'd1);
        tick();
        checks += 2;
        if (bus.out_result !== 16'h0011) begin errors++; $display("[TB] FAIL b2b_a_loaded got %h want 0011", bus.out_result); end
        if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_after_a got %0b want 1", bus.in_ready); end
        offer(16'h0022, 4'd2);
        tick();
        checks += 2;
        if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ready_after_b got %0b want 0", bus.in_ready); end
        if (bus.out_result !== 16'h0011) begin errors++; $display("[TB] FAIL b2b_a_held got %h want 0011", bus.out_result); end
        offer(16'h0033, 4'd3);
        tick();
        checks += 3;
        if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_c_withheld got %0b want 0", bus.in_ready); end
        if (bus.out_result !== 16'h0011) begin errors++; $display("[TB] FAIL b2b_a_stable got %h want 0011", bus.out_result); end
        if (bus.out_rd !== 4'd1) begin errors++; $display("[TB] FAIL b2b_a_rd_stable got %0d want 1", bus.out_rd); end
        bus.out_ready = 1'b1;
        tick();
        checks += 3;
        if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_b_valid got %0b want 1", bus.out_valid); end
        if (bus.out_result !== 16'h0022) begin errors++; $display("[TB] FAIL b2b_b_second got %h want 0022", bus.out_result); end
        if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_after_skid got %0b want 1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        checks += 2;
        if (bus.out_result !== 16'h0033) begin errors++; $display("[TB] FAIL b2b_c_third got %h want 0033", bus.out_result); end
        if (bus.out_store_data !== 16'hFFCC) begin errors++; $display("[TB] FAIL b2b_c_store got %h want ffcc", bus.out_store_data); end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drained got %0b want 0", bus.out_valid); end
    endtask

    task automatic test_flush();
        idleInputs();
        offer(16'h0101, 4'd1);
        tick();
        offer(16'h0202, 4'd2);
        tick();
        offer(16'h00FF, 4'd9);
        bus.flush = 1'b1;
        tick();
        idleInputs();
        checks += 2;
        if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_out_valid got %0b want 0", bus.out_valid); end
        if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_in_ready got %0b want 1", bus.in_ready); end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_dropped_emerged cycle %0d result %h want no valid", i, bus.out_result); end
        end
    endtask

    task automatic test_stall_saturation();
        idleInputs();
        doReset();
        offer(16'h5A5A, 4'd4);
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.stall_cnt !== 8'd0) begin errors++; $display("[TB] FAIL stall_start got %0d want 0", bus.stall_cnt); end
        for (int i = 0; i < 100; i++) tick();
        checks++;
        if (bus.stall_cnt !== 8'd100) begin errors++; $display("[TB] FAIL stall_100 got %0d want 100", bus.stall_cnt); end
        for (int i = 0; i < 200; i++) tick();
        checks += 2;
        if (bus.stall_cnt !== 8'd255) begin errors++; $display("[TB] FAIL stall_saturate got %0d want 255", bus.stall_cnt); end
        if (bus.out_result !== 16'h5A5A) begin errors++; $display("[TB] FAIL stall_hold_result got %h want 5a5a", bus.out_result); end
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        checks += 2;
        if (bus.stall_cnt !== 8'd255) begin errors++; $display("[TB] FAIL stall_after_flush got %0d want 255", bus.stall_cnt); end
        if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_flush_valid got %0b want 0", bus.out_valid); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (bus.stall_cnt !== 8'd0) begin errors++; $display("[TB] FAIL stall_reset got %0d want 0", bus.stall_cnt); end
    endtask

    task automatic test_reset_mid();
        idleInputs();
        offer(16'h0A0A, 4'd10);
        tick();
        offer(16'h0B0B, 4'd11);
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL midreset_full got %0b want 0", bus.in_ready); end
        bus.out_ready = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks += 3;
        if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_out_valid got %0b want 0", bus.out_valid); end
        if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_in_ready got %0b want 1", bus.in_ready); end
        if (bus.out_result !== 16'h0000) begin errors++; $display("[TB] FAIL midreset_out_result got %h want 0000", bus.out_result); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_ghost cycle %0d result %h want no valid", i, bus.out_result); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        idleInputs();
        test_reset();
        test_slt();
        test_non_slt();
        test_back_to_back();
        test_flush();
        test_stall_saturation();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
